// File: rtl/rs232_pkg.sv
// Shared RS232 link definitions: UART register map, status bits, default image size
// and the transmit-side state encoding. Also used by the receive path.
package rs232_pkg;

  localparam logic [4:0] RX_BASE     = 5'd0;
  localparam logic [4:0] TX_BASE     = 5'd4;
  localparam logic [4:0] STATUS_BASE = 5'd8;

  localparam int TX_OK_BIT = 6;
  localparam int RX_OK_BIT = 7;

  localparam int IMAGE_SIZE_DEFAULT = 307200;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_POLL,
    S_SEND,
    S_DONE
  } tx_state_t;

endpackage

// File: rtl/rs232_image_sender.sv
// Streams IMAGE_SIZE pixels from SRAM to the host through the Avalon-MM RS232 UART.
// Optional feature: define RS232_CHECKSUM_EN to append an 8-bit modular sum byte.
module rs232_image_sender
  import rs232_pkg::*;
#(
  parameter int IMAGE_SIZE = IMAGE_SIZE_DEFAULT,
  parameter int ADDR_W     = 20
) (
  input  logic              avm_clk,
  input  logic              avm_rst,
  output logic [4:0]        avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_waitrequest,
  input  logic              start,
  output logic              sram_req,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [7:0]        sram_rdata,
  input  logic              sram_rvalid,
  output logic              busy,
  output logic              send_finish
);

  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(IMAGE_SIZE - 1);

  tx_state_t         state, state_next;
  logic [4:0]        avm_address_next;
  logic              avm_read_next, avm_write_next;
  logic [31:0]       avm_writedata_next;
  logic              sram_req_next;
  logic [ADDR_W-1:0] sram_addr_next;
  logic              busy_next, send_finish_next;
  logic [ADDR_W-1:0] pix_cnt, pix_cnt_next;
  logic [7:0]        tx_byte, tx_byte_next;
  logic              last_pixel, tx_ok, launch;

`ifdef RS232_CHECKSUM_EN
  logic [7:0] checksum, checksum_next;
  logic       sending_sum, sending_sum_next;
`endif

  // Only the TX_OK flag of the status word matters on this side of the link.
  logic unused_readdata;
  assign unused_readdata = ^{avm_readdata[31:TX_OK_BIT+1], avm_readdata[TX_OK_BIT-1:0]};

  assign tx_ok      = avm_readdata[TX_OK_BIT];
  assign last_pixel = (pix_cnt == LAST_PIX);
  assign launch     = start && (state == S_IDLE || state == S_DONE);

  always_ff @(posedge avm_clk) begin
    if (avm_rst) begin
      state         <= S_IDLE;
      avm_address   <= STATUS_BASE;
      avm_read      <= 1'b0;
      avm_write     <= 1'b0;
      avm_writedata <= '0;
      sram_req      <= 1'b0;
      sram_addr     <= '0;
      busy          <= 1'b0;
      send_finish   <= 1'b0;
      pix_cnt       <= '0;
      tx_byte       <= '0;
`ifdef RS232_CHECKSUM_EN
      checksum      <= '0;
      sending_sum   <= 1'b0;
`endif
    end else begin
      state         <= state_next;
      avm_address   <= avm_address_next;
      avm_read      <= avm_read_next;
      avm_write     <= avm_write_next;
      avm_writedata <= avm_writedata_next;
      sram_req      <= sram_req_next;
      sram_addr     <= sram_addr_next;
      busy          <= busy_next;
      send_finish   <= send_finish_next;
      pix_cnt       <= pix_cnt_next;
      tx_byte       <= tx_byte_next;
`ifdef RS232_CHECKSUM_EN
      checksum      <= checksum_next;
      sending_sum   <= sending_sum_next;
`endif
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE, S_DONE: if (launch) state_next = S_FETCH;
      S_FETCH:        if (sram_rvalid) state_next = S_POLL;
      S_POLL:         if (!avm_waitrequest && tx_ok) state_next = S_SEND;
      S_SEND: begin
        if (!avm_waitrequest) begin
`ifdef RS232_CHECKSUM_EN
          if (sending_sum)     state_next = S_DONE;
          else if (last_pixel) state_next = S_POLL;
          else                 state_next = S_FETCH;
`else
          state_next = last_pixel ? S_DONE : S_FETCH;
`endif
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Registered-output values; anything not touched below holds its current value.
  always_comb begin
    avm_address_next   = avm_address;
    avm_read_next      = avm_read;
    avm_write_next     = avm_write;
    avm_writedata_next = avm_writedata;
    sram_req_next      = 1'b0;
    sram_addr_next     = sram_addr;
    busy_next          = busy;
    send_finish_next   = send_finish;
    pix_cnt_next       = pix_cnt;
    tx_byte_next       = tx_byte;
`ifdef RS232_CHECKSUM_EN
    checksum_next      = checksum;
    sending_sum_next   = sending_sum;
`endif
    unique case (state)
      S_IDLE, S_DONE: begin
        if (launch) begin
          sram_addr_next   = '0;
          sram_req_next    = 1'b1;
          busy_next        = 1'b1;
          send_finish_next = 1'b0;
          pix_cnt_next     = '0;
`ifdef RS232_CHECKSUM_EN
          checksum_next    = '0;
          sending_sum_next = 1'b0;
`endif
        end
      end
      S_FETCH: begin
        if (sram_rvalid) begin
          tx_byte_next     = sram_rdata;
          avm_read_next    = 1'b1;
          avm_address_next = STATUS_BASE;
`ifdef RS232_CHECKSUM_EN
          checksum_next    = checksum + sram_rdata;
`endif
        end
      end
      S_POLL: begin
        if (!avm_waitrequest && tx_ok) begin
          avm_read_next      = 1'b0;
          avm_write_next     = 1'b1;
          avm_address_next   = TX_BASE;
          avm_writedata_next = {24'b0, tx_byte};
        end
      end
      S_SEND: begin
        if (!avm_waitrequest) begin
          avm_write_next = 1'b0;
`ifdef RS232_CHECKSUM_EN
          if (sending_sum) begin
            busy_next        = 1'b0;
            send_finish_next = 1'b1;
          end else begin
            pix_cnt_next = pix_cnt + ADDR_W'(1);
            if (last_pixel) begin
              // The sum byte reuses the status-poll/send path without an SRAM fetch.
              tx_byte_next     = checksum;
              avm_read_next    = 1'b1;
              avm_address_next = STATUS_BASE;
              sending_sum_next = 1'b1;
            end else begin
              sram_addr_next = sram_addr + ADDR_W'(1);
              sram_req_next  = 1'b1;
            end
          end
`else
          pix_cnt_next = pix_cnt + ADDR_W'(1);
          if (last_pixel) begin
            busy_next        = 1'b0;
            send_finish_next = 1'b1;
          end else begin
            sram_addr_next = sram_addr + ADDR_W'(1);
            sram_req_next  = 1'b1;
          end
`endif
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rs232_image_sender.sv
// Self-checking bench for rs232_image_sender: SRAM and UART slave models, byte-stream scoreboard.
// Expected stream includes the checksum byte when RS232_CHECKSUM_EN is defined.
module tb_rs232_image_sender;
  import rs232_pkg::*;

  localparam int N_PIX  = 4;
  localparam int ADDR_W = 20;

  logic              avm_clk = 1'b0;
  logic              avm_rst = 1'b1;
  logic [4:0]        avm_address;
  logic              avm_read, avm_write;
  logic [31:0]       avm_writedata;
  logic [31:0]       avm_readdata = '0;
  logic              avm_waitrequest = 1'b0;
  logic              start = 1'b0;
  logic              sram_req;
  logic [ADDR_W-1:0] sram_addr;
  logic [7:0]        sram_rdata = '0;
  logic              sram_rvalid = 1'b0;
  logic              busy, send_finish;

  rs232_image_sender #(.IMAGE_SIZE(N_PIX), .ADDR_W(ADDR_W)) dut (
    .avm_clk(avm_clk), .avm_rst(avm_rst),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest), .start(start),
    .sram_req(sram_req), .sram_addr(sram_addr), .sram_rdata(sram_rdata),
    .sram_rvalid(sram_rvalid), .busy(busy), .send_finish(send_finish)
  );

  always #5 avm_clk = ~avm_clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [N_PIX];
  logic [7:0] write_log[$];
  logic [7:0] exp_q[$];
  int sram_latency = 1;
  int not_ok_left = 0;
  int wr_stall_left = 0;
  int stall_seen = 0;
  int reads_before_first = 0;
  bit rand_stall = 1'b0;

  bit pend_valid = 1'b0;
  int pend_cnt = 0;
  int pend_addr = 0;
  logic last_rst = 1'b1, last_read = 1'b0, last_write = 1'b0, last_wait = 1'b0;
  logic [4:0]  last_addr = '0;
  logic [31:0] last_data = '0;

  task automatic checkOutput(string tag, logic [63:0] observed, logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // SRAM and UART slave models run on the falling edge, away from the DUT's sampling edge.
  always @(negedge avm_clk) begin
    logic        wait_v;
    logic [31:0] word;
    if (!last_rst) begin
      if (last_write && !last_wait) begin
        write_log.push_back(last_data[7:0]);
        checkOutput("write_addr", 64'(last_addr), 64'(TX_BASE));
        checkOutput("write_upper", 64'(last_data[31:8]), 64'd0);
      end
      if (last_read && !last_wait) begin
        checkOutput("read_addr", 64'(last_addr), 64'(STATUS_BASE));
        if (write_log.size() == 0) reads_before_first++;
      end
      if (last_wait && (last_write || last_read))
        checkOutput("stall_hold", {25'b0, avm_write, avm_read, avm_address, avm_writedata},
                    {25'b0, last_write, last_read, last_addr, last_data});
    end
    checkOutput("rd_wr_exclusive", 64'(avm_read & avm_write), 64'd0);

    sram_rvalid = 1'b0;
    if (avm_rst) pend_valid = 1'b0;
    else begin
      if (sram_req) begin
        checkOutput("sram_addr_range", 64'(sram_addr < N_PIX), 64'd1);
        pend_valid = 1'b1;
        pend_cnt   = sram_latency;
        pend_addr  = int'(sram_addr) % N_PIX;
      end
      if (pend_valid) begin
        if (pend_cnt <= 1) begin
          sram_rvalid = 1'b1;
          sram_rdata  = mem[pend_addr];
          pend_valid  = 1'b0;
        end else pend_cnt--;
      end
      if (pend_valid) checkOutput("no_req_before_rvalid", 64'({avm_read, avm_write}), 64'd0);
    end

    wait_v = 1'b0;
    if (avm_write && wr_stall_left > 0) begin
      wait_v = 1'b1;
      wr_stall_left--;
      stall_seen++;
    end else if (rand_stall && (avm_read || avm_write)) wait_v = ($urandom_range(0, 3) == 0);
    word = $urandom;
    word[TX_OK_BIT] = (not_ok_left == 0);
    if (avm_read && !wait_v && !avm_rst && not_ok_left > 0) not_ok_left--;
    avm_waitrequest = wait_v;
    avm_readdata    = word;

    last_rst   = avm_rst;
    last_read  = avm_read;
    last_write = avm_write;
    last_wait  = wait_v;
    last_addr  = avm_address;
    last_data  = avm_writedata;
  end

  task automatic tick();
    @(posedge avm_clk);
    #1;
  endtask

  task automatic applyStimulus(logic [7:0] p0, logic [7:0] p1, logic [7:0] p2, logic [7:0] p3);
    int sum;
    mem[0] = p0; mem[1] = p1; mem[2] = p2; mem[3] = p3;
    exp_q.delete();
    sum = 0;
    for (int i = 0; i < N_PIX; i++) begin
      exp_q.push_back(mem[i]);
      sum += int'(mem[i]);
    end
`ifdef RS232_CHECKSUM_EN
    exp_q.push_back(8'(sum % 256));
`endif
    write_log.delete();
    reads_before_first = 0;
    stall_seen = 0;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic waitDone(string tag);
    int n = 0;
    while (send_finish !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    checkOutput({tag, "_finish"}, 64'(send_finish), 64'd1);
    checkOutput({tag, "_busy_low"}, 64'(busy), 64'd0);
    tick();
  endtask

  task automatic checkStream(string tag);
    checkOutput({tag, "_len"}, 64'(write_log.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < write_log.size())
        checkOutput($sformatf("%s_byte%0d", tag, i), 64'(write_log[i]), 64'(exp_q[i]));
  endtask

  task automatic checkResetOutputs(string tag);
    checkOutput({tag, "_read"}, 64'(avm_read), 64'd0);
    checkOutput({tag, "_write"}, 64'(avm_write), 64'd0);
    checkOutput({tag, "_address"}, 64'(avm_address), 64'(STATUS_BASE));
    checkOutput({tag, "_writedata"}, 64'(avm_writedata), 64'd0);
    checkOutput({tag, "_sram_req"}, 64'(sram_req), 64'd0);
    checkOutput({tag, "_sram_addr"}, 64'(sram_addr), 64'd0);
    checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
    checkOutput({tag, "_send_finish"}, 64'(send_finish), 64'd0);
  endtask

  initial begin
    int n;
    applyStimulus(8'h11, 8'h22, 8'h33, 8'h44);
    avm_rst = 1'b1;
    tick();
    tick();
    checkResetOutputs("reset");
    avm_rst = 1'b0;
    tick();

    $display("[TB] basic stream with start ignored while busy");
    pulseStart();
    checkOutput("start_busy", 64'(busy), 64'd1);
    checkOutput("start_sram_req", 64'(sram_req), 64'd1);
    checkOutput("start_sram_addr", 64'(sram_addr), 64'd0);
    tick();
    checkOutput("sram_req_one_cycle", 64'(sram_req), 64'd0);
    tick();
    tick();
    pulseStart();
    checkOutput("restart_ignored_busy", 64'(busy), 64'd1);
    waitDone("basic");
    checkStream("basic");

    $display("[TB] TX_OK low for five status reads");
    applyStimulus(8'h11, 8'h22, 8'h33, 8'h44);
    not_ok_left = 5;
    pulseStart();
    waitDone("txok");
    checkOutput("txok_reads", 64'(reads_before_first), 64'd6);
    checkStream("txok");

    $display("[TB] write stalled three cycles");
    applyStimulus(8'h11, 8'h22, 8'h33, 8'h44);
    wr_stall_left = 3;
    pulseStart();
    waitDone("stall");
    checkOutput("stall_cycles", 64'(stall_seen), 64'd3);
    checkStream("stall");

    $display("[TB] slow SRAM");
    applyStimulus(8'h11, 8'h22, 8'h33, 8'h44);
    sram_latency = 7;
    pulseStart();
    waitDone("slow");
    checkStream("slow");
    sram_latency = 1;

    $display("[TB] reset mid-transfer");
    applyStimulus(8'h11, 8'h22, 8'h33, 8'h44);
    pulseStart();
    n = 0;
    while (write_log.size() < 2 && n < 500) begin
      tick();
      n++;
    end
    checkOutput("abort_reached_pixel2", 64'(write_log.size()), 64'd2);
    tick();
    avm_rst = 1'b1;
    tick();
    checkResetOutputs("abort");
    avm_rst = 1'b0;
    tick();
    tick();
    applyStimulus(8'h11, 8'h22, 8'h33, 8'h44);
    pulseStart();
    waitDone("resend");
    checkStream("resend");

    for (int r = 0; r < 4; r++) begin
      $display("[TB] random round %0d", r);
      applyStimulus(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      sram_latency  = $urandom_range(1, 7);
      not_ok_left   = $urandom_range(0, 3);
      wr_stall_left = $urandom_range(0, 2);
      rand_stall    = 1'b1;
      pulseStart();
      waitDone($sformatf("rand%0d", r));
      checkStream($sformatf("rand%0d", r));
    end
    rand_stall = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
